// File: rtl/pipo_shift_pkg.sv
// Shared types for pipo_shift_reg: IDLE-state shift modes and transfer FSM states.
package pipo_shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_SHR  = 2'b11
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

endpackage

// File: rtl/pipo_shift_reg_xfer_ctrl.sv
// Serial-transfer sequencer: IDLE/XFER FSM plus shift counter for pipo_shift_reg.
module xfer_ctrl
  import pipo_shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic clk,
  input  logic res,
  input  logic en,
  input  logic start,
  output logic busy,
  output logic done,
  output logic load,
  output logic shift
);

  localparam int CW = $clog2(N + 1);

  state_t          state;
  logic [CW-1:0]   cnt;

  assign busy  = (state == ST_XFER);
  assign load  = en && (state == ST_IDLE) && start;
  assign shift = en && (state == ST_XFER);

  // done is a registered one-cycle pulse; any edge other than the last shift clears it
  always_ff @(posedge clk) begin
    if (res) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state <= ST_XFER;
        cnt   <= CW'(N);
      end else if (shift) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipo_shift_reg.sv
// N-bit PIPO register with hold/load/shift modes and an SPI-style full-duplex transfer engine.
// Optional even-parity output PAR when PIPO_SHIFT_PARITY_EN is defined.
module pipo_shift_reg
  import pipo_shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         res,
  input  logic         EN,
  input  logic [1:0]   MODE,
  input  logic [N-1:0] D,
  input  logic         SI_L,
  input  logic         SI_R,
  input  logic         START,
  output logic [N-1:0] Q,
`ifdef PIPO_SHIFT_PARITY_EN
  output logic         PAR,
`endif
  output logic         SO,
  output logic         BUSY,
  output logic         DONE
);

  logic load;
  logic shift;

  xfer_ctrl #(.N(N)) u_ctrl (
    .clk   (CLK),
    .res   (res),
    .en    (EN),
    .start (START),
    .busy  (BUSY),
    .done  (DONE),
    .load  (load),
    .shift (shift)
  );

  // START takes priority over MODE in IDLE; MODE only acts when no transfer is running
  always_ff @(posedge CLK) begin
    if (res) begin
      Q <= '0;
    end else if (EN) begin
      if (load) begin
        Q <= D;
      end else if (shift) begin
        Q <= {Q[N-2:0], SI_R};
      end else if (!BUSY) begin
        case (mode_t'(MODE))
          MODE_LOAD: Q <= D;
          MODE_SHL:  Q <= {Q[N-2:0], SI_R};
          MODE_SHR:  Q <= {SI_L, Q[N-1:1]};
          default:   Q <= Q;
        endcase
      end
    end
  end

  assign SO = Q[N-1];

`ifdef PIPO_SHIFT_PARITY_EN
  assign PAR = ^Q;
`endif

endmodule

// File: tb/tb_pipo_shift_reg.sv
// Self-checking bench for pipo_shift_reg (N=8): directed table, corner sequences, random vs. model.
module tb_pipo_shift_reg;

  localparam int N = 8;

  logic         CLK = 1'b0;
  logic         res;
  logic         EN;
  logic [1:0]   MODE;
  logic [N-1:0] D;
  logic         SI_L;
  logic         SI_R;
  logic         START;
  logic [N-1:0] Q;
  logic         SO;
  logic         BUSY;
  logic         DONE;
`ifdef PIPO_SHIFT_PARITY_EN
  logic         PAR;
`endif

  pipo_shift_reg #(.N(N)) dut (
    .CLK   (CLK),
    .res   (res),
    .EN    (EN),
    .MODE  (MODE),
    .D     (D),
    .SI_L  (SI_L),
    .SI_R  (SI_R),
    .START (START),
    .Q     (Q),
`ifdef PIPO_SHIFT_PARITY_EN
    .PAR   (PAR),
`endif
    .SO    (SO),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: register value, shifts still owed, pending done pulse
  logic [N-1:0] m_q    = '0;
  int           m_left = 0;
  logic         m_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (res) begin
      m_q = '0; m_left = 0; m_done = 1'b0;
    end else if (!EN) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_q    = N'((int'(m_q) * 2 + int'(SI_R)) % (1 << N));
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end else begin
      m_done = 1'b0;
      if (START) begin
        m_q = D; m_left = N;
      end else begin
        case (MODE)
          2'd1: m_q = D;
          2'd2: m_q = N'((int'(m_q) * 2 + int'(SI_R)) % (1 << N));
          2'd3: m_q = N'(int'(m_q) / 2 + (int'(SI_L) << (N - 1)));
          default: ;
        endcase
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
    check("q", 32'(Q), 32'(m_q));
    check("busy", 32'(BUSY), 32'(m_left > 0));
    check("done", 32'(DONE), 32'(m_done));
    check("so", 32'(SO), 32'(m_q[N-1]));
`ifdef PIPO_SHIFT_PARITY_EN
    check("par", 32'(PAR), 32'(^m_q));
`endif
  endtask

  task automatic wait_done(input int max, output int cycles);
    cycles = 0;
    while (!DONE && cycles < max) begin
      cycle();
      cycles++;
    end
    check("done_within_bound", 32'(DONE), 32'(1));
  endtask

  typedef struct {
    logic       r, e;
    logic [1:0] m;
    logic       s;
    logic [7:0] d;
    logic       sl, sr;
    logic [7:0] q;
    logic       b, dn;
  } vec_t;

  vec_t tbl[18];
  int   cyc;
  logic [7:0] so_bits;

  initial begin
    res = 1'b1; EN = 1'b1; MODE = 2'd0; D = '0; SI_L = 1'b0; SI_R = 1'b0; START = 1'b0;

    //            r  e  m     s  d      sl sr q      b  dn
    tbl[0]  = '{1, 1, 2'd1, 1, 8'hFF, 0, 0, 8'h00, 0, 0};
    tbl[1]  = '{0, 0, 2'd1, 0, 8'hAA, 0, 0, 8'h00, 0, 0};
    tbl[2]  = '{0, 0, 2'd1, 0, 8'hAA, 0, 0, 8'h00, 0, 0};
    tbl[3]  = '{0, 1, 2'd1, 0, 8'hAA, 0, 0, 8'hAA, 0, 0};
    tbl[4]  = '{0, 1, 2'd1, 0, 8'h81, 0, 0, 8'h81, 0, 0};
    tbl[5]  = '{0, 1, 2'd2, 0, 8'h00, 0, 0, 8'h02, 0, 0};
    tbl[6]  = '{0, 1, 2'd3, 0, 8'h00, 1, 0, 8'h81, 0, 0};
    tbl[7]  = '{0, 1, 2'd0, 0, 8'h00, 0, 1, 8'h81, 0, 0};
    tbl[8]  = '{0, 1, 2'd2, 1, 8'hA5, 0, 0, 8'hA5, 1, 0};
    tbl[9]  = '{0, 1, 2'd1, 0, 8'h00, 0, 1, 8'h4B, 1, 0};
    tbl[10] = '{0, 1, 2'd1, 1, 8'h00, 0, 0, 8'h96, 1, 0};
    tbl[11] = '{0, 1, 2'd3, 0, 8'h00, 1, 1, 8'h2D, 1, 0};
    tbl[12] = '{0, 1, 2'd0, 0, 8'h00, 0, 1, 8'h5B, 1, 0};
    tbl[13] = '{0, 1, 2'd0, 0, 8'h00, 0, 0, 8'hB6, 1, 0};
    tbl[14] = '{0, 1, 2'd0, 0, 8'h00, 0, 0, 8'h6C, 1, 0};
    tbl[15] = '{0, 1, 2'd0, 0, 8'h00, 0, 1, 8'hD9, 1, 0};
    tbl[16] = '{0, 1, 2'd0, 0, 8'h00, 0, 0, 8'hB2, 0, 1};
    tbl[17] = '{0, 1, 2'd0, 0, 8'h00, 0, 0, 8'hB2, 0, 0};

    for (int i = 0; i < 18; i++) begin
      res = tbl[i].r; EN = tbl[i].e; MODE = tbl[i].m; START = tbl[i].s;
      D = tbl[i].d; SI_L = tbl[i].sl; SI_R = tbl[i].sr;
      cycle();
      check($sformatf("vec%0d_q", i), 32'(Q), 32'(tbl[i].q));
      check($sformatf("vec%0d_busy", i), 32'(BUSY), 32'(tbl[i].b));
      check($sformatf("vec%0d_done", i), 32'(DONE), 32'(tbl[i].dn));
      check($sformatf("vec%0d_so", i), 32'(SO), 32'(tbl[i].q[7]));
    end

    // stall: 2 shifts, 3 frozen edges, then 6 more shifts before DONE
    res = 0; EN = 1; MODE = 2'd0; START = 1; D = 8'h5A; SI_R = 1;
    cycle();
    START = 0;
    cycle(); cycle();
    EN = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_busy", 32'(BUSY), 32'(1));
      check("stall_no_done", 32'(DONE), 32'(0));
    end
    EN = 1;
    wait_done(20, cyc);
    check("stall_remaining_shifts", 32'(cyc), 32'(6));
    cycle();

    // abort: reset after 4 shifts, no DONE afterwards
    START = 1; D = 8'hFF; SI_R = 1;
    cycle();
    START = 0;
    for (int i = 0; i < 4; i++) cycle();
    res = 1;
    cycle();
    check("abort_q", 32'(Q), 32'(0));
    check("abort_busy", 32'(BUSY), 32'(0));
    res = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("abort_no_done", 32'(DONE), 32'(0));
    end

    // back-to-back: START held high through the DONE cycle
    START = 1; D = 8'h3C; SI_R = 0;
    cycle();
    wait_done(20, cyc);
    cycle();
    check("b2b_busy", 32'(BUSY), 32'(1));
    check("b2b_done_low", 32'(DONE), 32'(0));
    START = 0;
    so_bits = '0;
    for (int i = 0; i < 8; i++) begin
      so_bits = {so_bits[6:0], SO};
      cycle();
    end
    check("b2b_so_seq", 32'(so_bits), 32'(8'h3C));
    check("b2b_done", 32'(DONE), 32'(1));

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      res   = ($urandom_range(0, 39) == 0);
      EN    = ($urandom_range(0, 4) != 0);
      MODE  = 2'($urandom_range(0, 3));
      START = ($urandom_range(0, 7) == 0);
      D     = N'($urandom);
      SI_L  = 1'($urandom);
      SI_R  = 1'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipo_shift_reg.md
Name: pipo_shift_reg

Overview:
- Parametrised successor to the N-bit PIPO register with enable.
- Adds shift modes (hold / parallel load / shift left / shift right) and a serial-transfer engine.
- The engine shifts a loaded word out MSB-first while shifting a new word in, SPI-style full duplex.
- Sits between parallel datapath registers and serial links or peripherals.

Parameters:
N, 8, register width in bits (N >= 2)

Ports:
CLK    input   1    clock; one clock; all state updates on rising edge
res    input   1    reset; synchronous, active-high
EN     input   1    clock enable; EN=0 freezes all state (Q, FSM, counter)
MODE   input   2    IDLE-state op: 00 hold, 01 parallel load, 10 shift left, 11 shift right
D      input   N    parallel load data
SI_L   input   1    serial in for shift right (enters Q[N-1])
SI_R   input   1    serial in for shift left and for transfers (enters Q[0])
START  input   1    begin N-bit serial transfer of D
Q      output  N    register contents
SO     output  1    serial out = Q[N-1] (combinational from Q)
BUSY   output  1    1 while FSM in XFER
DONE   output  1    one-cycle pulse after the final transfer shift

Behaviour:
- Reset: synchronous, active-high; res=1 at a rising edge forces Q=0, state=IDLE, cnt=0, DONE=0 (so BUSY=0, SO=0). res has priority over EN, START and MODE.
- FSM states: IDLE, XFER. Counter cnt has width $clog2(N+1).
- Any edge with EN=0: nothing changes, and DONE is forced to 0 on that edge.

IDLE, EN=1:
- START=1: Q<=D, cnt<=N, state<=XFER. MODE is ignored.
- START=0, MODE=00: Q unchanged.
- MODE=01: Q<=D.
- MODE=10: Q<={Q[N-2:0],SI_R}.
- MODE=11: Q<={SI_L,Q[N-1:1]}.
- All ops have 1-cycle latency: Q is visible after the edge.

XFER, EN=1:
- Each edge: Q<={Q[N-2:0],SI_R}, cnt<=cnt-1.
- MODE and START are ignored; START while BUSY does not restart.
- When cnt==1 on the edge: state<=IDLE, DONE<=1.
- SO presents D[N-1], D[N-2] … D[0] on successive cycles, starting the cycle after START.
- After N shifts Q holds the N received SI_R bits, first-received in the MSB.

Other rules:
- XFER with EN=0 stalls: no shift, no count, BUSY stays 1.
- DONE is registered, high exactly one cycle, otherwise 0. START may be accepted the edge DONE is high (back-to-back transfers): DONE drops and BUSY rises together.
- Reset mid-transfer aborts the transfer: IDLE, Q=0, no DONE pulse.

Optional Feature:
- Macro PIPO_SHIFT_PARITY_EN.
- Defined: adds output port PAR (1 bit) = ^Q, even-parity bit of current Q, combinational. It is 0 after reset.
- Undefined: port PAR does not exist and there is no parity logic.

Decomposition:
- Package pipo_shift_pkg holds:
  - typedef enum logic [1:0] mode_t {MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR}
  - typedef enum logic state_t {ST_IDLE, ST_XFER}
- Sub-module xfer_ctrl (FSM + counter, outputs BUSY/DONE/shift strobe) is natural. Datapath mux stays in the top.

Test Plan (N=8):
- Reset: res=1 for 1 edge with D=8'hFF, MODE=01, START=1 -> Q=8'h00, BUSY=0, DONE=0.
- Enable hold: EN=0, MODE=01, D=8'hAA for 2 edges -> Q stays 8'h00. Then EN=1 -> Q=8'hAA after 1 edge.
- Shifts: Q=8'h81, MODE=10, SI_R=0 -> 8'h02. Then MODE=11, SI_L=1 -> 8'h81.
- Transfer: START with D=8'hA5, SI_R driven 1,0,1,1,0,0,1,0 -> SO sequence 1,0,1,0,0,1,0,1; BUSY high 8 cycles; DONE one pulse; final Q=8'hB2.
- Stall and abort:
  - EN=0 for 3 cycles mid-transfer -> BUSY held, cnt frozen, DONE pulse delayed 3 cycles.
  - res=1 after 4 shifts -> Q=0, BUSY=0, no DONE.
- Back-to-back: START held high through the DONE cycle with D=8'h3C -> second transfer begins immediately, SO=0,0,1,1,1,1,0,0. With PIPO_SHIFT_PARITY_EN, PAR=^Q checked every cycle (e.g. Q=8'hA5 -> PAR=0).
